// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 32-bit memory port between instruction fetch (port 0)
// and data load/store (port 1), with a per-access timeout against a hung memory.
module mem_port_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [DW-1:0] addr0,
  input  logic          req1,
  input  logic [DW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we1,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0] state;
  logic       last_grant;
  logic [7:0] cnt;
  logic [7:0] cnt_inc;
  logic       grant;
  logic       any_req;

  // Under contention the port that did not win last time is favoured.
  always_comb begin
    any_req = req0 | req1;
    cnt_inc = cnt + 8'd1;
    if (req0 && req1) begin
      grant = ~last_grant;
    end else begin
      grant = req1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= 8'd0;
      mem_req    <= 1'b0;
      mem_addr   <= {DW{1'b0}};
      mem_wdata  <= {DW{1'b0}};
      mem_we     <= 1'b0;
      sel        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata      <= {DW{1'b0}};
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel       <= grant;
            mem_addr  <= grant ? addr1 : addr0;
            mem_wdata <= grant ? wdata1 : {DW{1'b0}};
            mem_we    <= grant ? we1 : 1'b0;
            mem_req   <= 1'b1;
            cnt       <= 8'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // A completion in the final allowed cycle still wins over the timeout.
          if (mem_ready) begin
            rdata   <= mem_rdata;
            err     <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ack0    <= ~sel;
            ack1    <= sel;
            cnt     <= cnt_inc;
            state   <= DONE;
          end else if (cnt_inc == TIMEOUT_CNT) begin
            rdata   <= {DW{1'b0}};
            err     <= 1'b1;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ack0    <= ~sel;
            ack1    <= sel;
            cnt     <= cnt_inc;
            state   <= DONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: begin
          ack0       <= 1'b0;
          ack1       <= 1'b0;
          last_grant <= sel;
          cnt        <= 8'd0;
          state      <= IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          ack0    <= 1'b0;
          ack1    <= 1'b0;
          cnt     <= 8'd0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
